// File: rtl/ysyx_25030093_pkg.sv
// Shared LSU definitions: op codes, FSM state encoding and op classification helpers.
package ysyx_25030093_pkg;

  localparam logic [3:0] LSU_NONE = 4'b0000;
  localparam logic [3:0] LSU_LB   = 4'b0001;
  localparam logic [3:0] LSU_LH   = 4'b0010;
  localparam logic [3:0] LSU_LW   = 4'b0011;
  localparam logic [3:0] LSU_LBU  = 4'b0100;
  localparam logic [3:0] LSU_LHU  = 4'b0101;
  localparam logic [3:0] LSU_SB   = 4'b1000;
  localparam logic [3:0] LSU_SH   = 4'b1001;
  localparam logic [3:0] LSU_SW   = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unlisted encodings collapse to LSU_NONE so downstream logic sees only legal ops.
  function automatic logic [3:0] lsu_norm_op(input logic [3:0] op);
    case (op)
      LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
      LSU_SB, LSU_SH, LSU_SW: lsu_norm_op = op;
      default:                lsu_norm_op = LSU_NONE;
    endcase
  endfunction

  function automatic logic lsu_is_store(input logic [3:0] op);
    lsu_is_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic logic lsu_is_load(input logic [3:0] op);
    lsu_is_load = (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
                  (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

  function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: lsu_misaligned = off[0];
      LSU_LW, LSU_SW:          lsu_misaligned = (off != 2'b00);
      default:                 lsu_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_fsm_if.sv
// Data-memory request/response port of the LSU; master is the LSU, slave is the memory.
interface ysyx_25030093_lsu_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Request completes on a cycle with mem_req_valid && mem_req_ready; request fields
    // stay stable while valid is high. mem_rsp_valid is a single-cycle pulse, no backpressure.
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [3:0]        mem_req_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/ysyx_25030093_lsu_align.sv
// Byte-lane steering: store data shift + byte enables, load lane select + sign/zero extension.
module ysyx_25030093_lsu_align
    import ysyx_25030093_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] load_data
);
    logic [4:0]  shamt;
    logic [31:0] lane;

    assign shamt = {byte_off, 3'b000};
    assign lane  = load_word >> shamt;

    always_comb begin
        wdata = 32'h0;
        wmask = 4'b0000;
        case (op)
            LSU_SB: begin wdata = store_data << shamt; wmask = 4'b0001 << byte_off; end
            LSU_SH: begin wdata = store_data << shamt; wmask = 4'b0011 << byte_off; end
            LSU_SW: begin wdata = store_data;          wmask = 4'b1111;             end
            default: ;
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (op)
            LSU_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
            LSU_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
            LSU_LW:  load_data = lane;
            LSU_LBU: load_data = {24'h0, lane[7:0]};
            LSU_LHU: load_data = {16'h0, lane[15:0]};
            default: ;
        endcase
    end
endmodule

// File: rtl/ysyx_25030093_lsu_fsm.sv
// Multi-cycle load/store stage: accepts one op from EXU, performs at most one memory
// access, and holds the aligned result for WBU until it is taken.
module ysyx_25030093_lsu_fsm
    import ysyx_25030093_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // EXU side: accept when in_valid && out_ready (out_ready is high only in IDLE).
    input  logic              in_valid,
    output logic              out_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [3:0]        LSU_single,
    // WBU side: result held stable while out_valid && !in_ready.
    output logic              out_valid,
    input  logic              in_ready,
    output logic [DATA_W-1:0] LSU_data,
    output logic [DATA_W-1:0] pass_data,
    output logic              misalign,
    ysyx_25030093_lsu_fsm_if.master mem,
    output lsu_state_e        dbg_state
);
    lsu_state_e        state;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] store_q;
    logic              req_valid_q;
    logic [3:0]        op_n;
    logic [31:0]       al_wdata;
    logic [3:0]        al_wmask;
    logic [31:0]       al_load;

    assign op_n      = lsu_norm_op(LSU_single);
    assign out_ready = (state == ST_IDLE);
    assign dbg_state = state;

    // pass_data doubles as the latched effective address.
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_wen   = lsu_is_store(op_q);
    assign mem.mem_req_addr  = {pass_data[ADDR_W-1:2], 2'b00};
    assign mem.mem_req_wdata = al_wdata;
    assign mem.mem_req_wmask = al_wmask;

    ysyx_25030093_lsu_align u_align (
        .op         (op_q),
        .byte_off   (pass_data[1:0]),
        .store_data (store_q),
        .load_word  (mem.mem_rsp_rdata),
        .wdata      (al_wdata),
        .wmask      (al_wmask),
        .load_data  (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= LSU_NONE;
            store_q     <= '0;
            req_valid_q <= 1'b0;
            out_valid   <= 1'b0;
            misalign    <= 1'b0;
            LSU_data    <= '0;
            pass_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pass_data <= rd_data;
                        store_q   <= rs2_data;
                        op_q      <= op_n;
                        LSU_data  <= '0;
                        if (op_n == LSU_NONE) begin
                            out_valid <= 1'b1;
                            misalign  <= 1'b0;
                            state     <= ST_DONE;
                        end else if (lsu_misaligned(op_n, rd_data[1:0])) begin
                            out_valid <= 1'b1;
                            misalign  <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            misalign    <= 1'b0;
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                // A response coincident with the request handshake is seen in REQ and dropped.
                ST_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        LSU_data  <= lsu_is_load(op_q) ? al_load : '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_ready) begin
                        out_valid <= 1'b0;
                        misalign  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25030093_lsu_fsm.sv
// Directed bench for the LSU: vector table of single transactions plus hand-written hold/reset sequences.
module tb_ysyx_25030093_lsu_fsm;
    import ysyx_25030093_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, out_valid, in_ready, misalign;
    logic [31:0] rd_data, rs2_data, LSU_data, pass_data;
    logic [3:0]  LSU_single;
    lsu_state_e  dbg_state;

    ysyx_25030093_lsu_fsm_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ysyx_25030093_lsu_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .rd_data    (rd_data),
        .rs2_data   (rs2_data),
        .LSU_single (LSU_single),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .LSU_data   (LSU_data),
        .pass_data  (pass_data),
        .misalign   (misalign),
        .mem        (mem_bus),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr, rs2, rdata;
        int          req_wait, rsp_wait;
        bit          early_rsp;
        int          exp_nreq;
        logic        exp_wen;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata, exp_data;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [3:0] op, logic [31:0] a, logic [31:0] s,
                                logic [31:0] rd, int rqw, int rsw, bit er, int nq, logic wen,
                                logic [3:0] wm, logic [31:0] wd, logic [31:0] dat, logic mis,
                                int lat);
        vec_t v;
        v.name = n; v.op = op; v.addr = a; v.rs2 = s; v.rdata = rd;
        v.req_wait = rqw; v.rsp_wait = rsw; v.early_rsp = er; v.exp_nreq = nq;
        v.exp_wen = wen; v.exp_wmask = wm; v.exp_wdata = wd; v.exp_data = dat;
        v.exp_mis = mis; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_ready = 1'b0; rd_data = '0; rs2_data = '0; LSU_single = LSU_NONE;
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_rdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, nreq, req_cyc, wait_cyc;
        bit hs;
        lat = 0; nreq = 0; req_cyc = 0; wait_cyc = 0; hs = 1'b0;
        for (int i = 0; i < 20 && !out_ready; i++) step();
        chk({v.name, ".ready_in"}, {31'h0, out_ready}, 32'h1);
        in_valid = 1'b1; rd_data = v.addr; rs2_data = v.rs2; LSU_single = v.op;
        step();
        // Scramble EXU inputs so anything not latched shows up as wrong data.
        in_valid = 1'b0; rd_data = $urandom; rs2_data = $urandom; LSU_single = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid && lat < 60) begin
            mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_rdata = '0;
            chk({v.name, ".busy_ready"}, {31'h0, out_ready}, 32'h0);
            if (mem_bus.mem_req_valid) begin
                chk({v.name, ".addr"}, mem_bus.mem_req_addr, v.addr & 32'hFFFF_FFFC);
                chk({v.name, ".wen"}, {31'h0, mem_bus.mem_req_wen}, {31'h0, v.exp_wen});
                chk({v.name, ".wmask"}, {28'h0, mem_bus.mem_req_wmask}, {28'h0, v.exp_wmask});
                if (v.exp_wen) chk({v.name, ".wdata"}, mem_bus.mem_req_wdata, v.exp_wdata);
                if (req_cyc == v.req_wait) begin
                    mem_bus.mem_req_ready = 1'b1;
                    nreq++;
                    hs = 1'b1;
                    if (v.early_rsp) begin
                        mem_bus.mem_rsp_valid = 1'b1;
                        mem_bus.mem_rsp_rdata = 32'h5555_5555;
                    end
                end
                req_cyc++;
            end else if (hs) begin
                wait_cyc++;
                if (wait_cyc == v.rsp_wait) begin
                    mem_bus.mem_rsp_valid = 1'b1;
                    mem_bus.mem_rsp_rdata = v.rdata;
                end
            end
            step();
            lat++;
        end
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rsp_rdata = '0;
        chk({v.name, ".out_valid"}, {31'h0, out_valid}, 32'h1);
        chk({v.name, ".latency"}, lat, v.exp_lat);
        chk({v.name, ".nreq"}, nreq, v.exp_nreq);
        chk({v.name, ".LSU_data"}, LSU_data, v.exp_data);
        chk({v.name, ".misalign"}, {31'h0, misalign}, {31'h0, v.exp_mis});
        chk({v.name, ".pass_data"}, pass_data, v.addr);
        chk({v.name, ".req_dropped"}, {31'h0, mem_bus.mem_req_valid}, 32'h0);
        step();
        chk({v.name, ".hold_valid"}, {31'h0, out_valid}, 32'h1);
        chk({v.name, ".hold_data"}, LSU_data, v.exp_data);
        in_ready = 1'b1;
        chk({v.name, ".done_ready"}, {31'h0, out_ready}, 32'h0);
        step();
        in_ready = 1'b0;
        chk({v.name, ".released"}, {31'h0, out_valid}, 32'h0);
        chk({v.name, ".back_idle"}, {31'h0, out_ready}, 32'h1);
    endtask

    initial begin
        vecs.push_back(mk("lw_word",  LSU_LW,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 5));
        vecs.push_back(mk("lb_sext",  LSU_LB,  32'h8000_0003, 32'h0, 32'h8011_2233, 0, 1, 0, 1, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 3));
        vecs.push_back(mk("lbu_zext", LSU_LBU, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 1, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 3));
        vecs.push_back(mk("sh_hi",    LSU_SH,  32'h8000_0002, 32'h0000_ABCD, 32'h1234_5678, 2, 1, 0, 1, 1'b1, 4'b1100, 32'hABCD_0000, 32'h0, 1'b0, 5));
        vecs.push_back(mk("lw_mis",   LSU_LW,  32'h8000_0001, 32'h0, 32'h0, 0, 1, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1));
        vecs.push_back(mk("lh_early", LSU_LH,  32'h8000_0002, 32'h0, 32'h8001_1234, 0, 2, 1, 1, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 4));
        vecs.push_back(mk("lhu_lo",   LSU_LHU, 32'h8000_0000, 32'h0, 32'h1234_F00D, 0, 1, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_F00D, 1'b0, 3));
        vecs.push_back(mk("sb_lane1", LSU_SB,  32'h8000_0001, 32'h0000_00A5, 32'h0, 1, 1, 0, 1, 1'b1, 4'b0010, 32'h0000_A500, 32'h0, 1'b0, 4));
        vecs.push_back(mk("sb_lane3", LSU_SB,  32'h8000_0003, 32'h1234_5678, 32'h0, 0, 1, 0, 1, 1'b1, 4'b1000, 32'h7800_0000, 32'h0, 1'b0, 3));
        vecs.push_back(mk("sw_full",  LSU_SW,  32'h8000_0008, 32'hCAFE_BABE, 32'h0, 0, 1, 0, 1, 1'b1, 4'b1111, 32'hCAFE_BABE, 32'h0, 1'b0, 3));
        vecs.push_back(mk("sh_mis",   LSU_SH,  32'h8000_0003, 32'h0000_1111, 32'h0, 0, 1, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1, 1));
        vecs.push_back(mk("none",     LSU_NONE, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1));
        vecs.push_back(mk("unk_op",   4'b0111, 32'h0000_5678, 32'h0, 32'h0, 0, 1, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1));
        vecs.push_back(mk("lb_pos",   LSU_LB,  32'h8000_0000, 32'h0, 32'h0000_007F, 0, 1, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_007F, 1'b0, 3));
        vecs.push_back(mk("lw_slow",  LSU_LW,  32'h8000_0000, 32'h0, 32'h0102_0304, 3, 2, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0102_0304, 1'b0, 7));

        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst.state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("rst.misalign", {31'h0, misalign}, 32'h0);
        chk("rst.LSU_data", LSU_data, 32'h0);
        chk("rst.pass_data", pass_data, 32'h0);
        chk("rst.out_ready", {31'h0, out_ready}, 32'h1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // WBU stalls a pass-through result for four cycles.
        in_valid = 1'b1; rd_data = 32'h0000_1234; LSU_single = LSU_NONE;
        step();
        in_valid = 1'b0; rd_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk("hold.out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold.pass_data", pass_data, 32'h0000_1234);
            chk("hold.out_ready", {31'h0, out_ready}, 32'h0);
            step();
        end
        in_ready = 1'b1;
        chk("hold.hs_ready", {31'h0, out_ready}, 32'h0);
        step();
        in_ready = 1'b0;
        chk("hold.released", {31'h0, out_valid}, 32'h0);
        chk("hold.idle_ready", {31'h0, out_ready}, 32'h1);

        // Reset lands while a load waits for its response; a late response must be ignored.
        in_valid = 1'b1; rd_data = 32'h8000_0010; LSU_single = LSU_LW;
        step();
        in_valid = 1'b0;
        chk("rstw.req", {31'h0, mem_bus.mem_req_valid}, 32'h1);
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        chk("rstw.in_wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw.state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        chk("rstw.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rstw.req_valid", {31'h0, mem_bus.mem_req_valid}, 32'h0);
        chk("rstw.pass_data", pass_data, 32'h0);
        chk("rstw.LSU_data", LSU_data, 32'h0);
        mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_rdata = 32'hFFFF_FFFF;
        step();
        mem_bus.mem_rsp_valid = 1'b0;
        chk("late.state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        chk("late.out_valid", {31'h0, out_valid}, 32'h0);
        chk("late.LSU_data", LSU_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
